apb3_master_bridge: RTL



---
 rtl/apb3_master_bridge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apb3_master_bridge.sv
// ---------------------------------------------------------------------------
// apb3_master_bridge
//
// APB3 initiator. It turns a valid/ready request port into APB3 SETUP/ACCESS
// transfers and returns the read data and error status on a valid/ready
// response port. Only one transaction is outstanding at a time, and the
// bridge honours slave wait states.
//
// Optional feature: define APB3_MASTER_BRIDGE_TIMEOUT_EN to abort an ACCESS
// phase that has waited TIMEOUT_CYCLES cycles with PREADY low. An aborted
// transfer returns rsp_err=1 and rsp_rdata=0. When the macro is undefined,
// ACCESS waits for PREADY with no limit.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (req_ready is high only in IDLE)
//   req_is_wr         1 = write, 0 = read
//   req_addr          byte address, copied to PADDR unchanged
//   req_wdata         write data, copied to PWDATA
//   rsp_valid/ready   response handshake
//   rsp_rdata         read data, 0 for writes or on timeout
//   rsp_err           captured PSLVERR, or timeout
//   PSEL..PWDATA      APB3 request outputs, all registered
//   PRDATA, PREADY,
//   PSLVERR           APB3 completer inputs
// ---------------------------------------------------------------------------
module apb3_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                state, state_nxt;
    logic                  psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

`ifdef APB3_MASTER_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             tmo_hit;

    // The counter holds the number of wait cycles already spent in ACCESS.
    // The current cycle is the last permitted one when the counter is one
    // short of the limit. That gives exactly TIMEOUT_CYCLES ACCESS cycles
    // before PSEL drops.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
        end
    end
`endif

    // req_ready is the only combinational output. It is a decode of IDLE.
    assign req_ready = (state == IDLE);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Next-state and next-output decode. Each register holds its value by
    // default. A state only drives the fields it changes at its exit edge.
    // PRDATA and PSLVERR are sampled only on a completing ACCESS cycle.
    always_comb begin
        state_nxt     = state;
        psel_nxt      = PSEL;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
`ifdef APB3_MASTER_BRIDGE_TIMEOUT_EN
        tmo_cnt_nxt   = tmo_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    pwrite_nxt  = req_is_wr;
                    paddr_nxt   = req_addr;
                    pwdata_nxt  = req_wdata;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
`ifdef APB3_MASTER_BRIDGE_TIMEOUT_EN
                tmo_cnt_nxt = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_err_nxt   = PSLVERR;
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
`ifdef APB3_MASTER_BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
